// File: rtl/orpsoc_flashrom_wb_reader.sv
// rtl/orpsoc_flashrom_wb_reader.sv - Wishbone word reader for the byte-wide UFROM with one-word cache
`timescale 1ns/1ps
module orpsoc_flashrom_wb_reader #(
    parameter int ROM_LAT  = 1,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [6:0]  rom_addr_o,
    input  logic [7:0]  rom_dout_i
);

    localparam logic [1:0] LAT = 2'(ROM_LAT);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_idx, byte_idx_nxt;
    logic [1:0]  wait_cnt, wait_nxt;
    logic [23:0] partial, partial_nxt;
    logic [4:0]  tag, tag_nxt;
    logic [31:0] cache_word, cache_word_nxt;
    logic [4:0]  cache_tag, cache_tag_nxt;
    logic        cache_valid, cache_valid_nxt;
    logic [31:0] dat_nxt;
    logic        ack_nxt, err_nxt;
    logic [6:0]  addr_nxt;
    logic        active, req, hit, byte_done;
    logic        unused_bits;

    // Write data, byte selects and the upstream-decoded address bits play no part in a read.
    assign unused_bits = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:7], wb_adr_i[1:0]};

    assign active    = wb_cyc_i & wb_stb_i;
    assign req       = active & ~wb_ack_o & ~wb_err_o;
    assign hit       = CACHE_EN && cache_valid && (cache_tag == wb_adr_i[6:2]);
    assign byte_done = (wait_cnt == LAT);

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state <= IDLE;
        else             state <= state_nxt;
    end

    // Next state: misses enter FETCH, the final byte enters RESP, a dropped strobe abandons the fetch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req && !wb_we_i && !hit) state_nxt = FETCH;
            FETCH:   if (!active) state_nxt = IDLE;
                     else if (byte_done && byte_idx == 2'd3) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath next values; the ack is registered on the edge entering RESP, so RESP is the ack cycle.
    always_comb begin
        dat_nxt         = wb_dat_o;
        ack_nxt         = 1'b0;
        err_nxt         = 1'b0;
        addr_nxt        = rom_addr_o;
        byte_idx_nxt    = byte_idx;
        wait_nxt        = wait_cnt;
        partial_nxt     = partial;
        tag_nxt         = tag;
        cache_word_nxt  = cache_word;
        cache_tag_nxt   = cache_tag;
        cache_valid_nxt = cache_valid;
        case (state)
            IDLE: begin
                if (req) begin
                    if (wb_we_i) begin
                        err_nxt = 1'b1;
                    end else if (hit) begin
                        ack_nxt = 1'b1;
                        dat_nxt = cache_word;
                    end else begin
                        addr_nxt     = {wb_adr_i[6:2], 2'b00};
                        tag_nxt      = wb_adr_i[6:2];
                        byte_idx_nxt = 2'd0;
                        wait_nxt     = 2'd0;
                    end
                end
            end
            FETCH: begin
                if (active) begin
                    if (byte_done) begin
                        if (byte_idx == 2'd3) begin
                            dat_nxt = {partial, rom_dout_i};
                            ack_nxt = 1'b1;
                            if (CACHE_EN) begin
                                cache_word_nxt  = {partial, rom_dout_i};
                                cache_tag_nxt   = tag;
                                cache_valid_nxt = 1'b1;
                            end
                        end else begin
                            case (byte_idx)
                                2'd0:    partial_nxt[23:16] = rom_dout_i;
                                2'd1:    partial_nxt[15:8]  = rom_dout_i;
                                default: partial_nxt[7:0]   = rom_dout_i;
                            endcase
                            byte_idx_nxt = byte_idx + 2'd1;
                            addr_nxt     = rom_addr_o + 7'd1;
                            wait_nxt     = 2'd0;
                        end
                    end else begin
                        wait_nxt = wait_cnt + 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath, bus outputs and cache registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            rom_addr_o  <= '0;
            byte_idx    <= '0;
            wait_cnt    <= '0;
            partial     <= '0;
            tag         <= '0;
            cache_word  <= '0;
            cache_tag   <= '0;
            cache_valid <= 1'b0;
        end else begin
            wb_dat_o    <= dat_nxt;
            wb_ack_o    <= ack_nxt;
            wb_err_o    <= err_nxt;
            rom_addr_o  <= addr_nxt;
            byte_idx    <= byte_idx_nxt;
            wait_cnt    <= wait_nxt;
            partial     <= partial_nxt;
            tag         <= tag_nxt;
            cache_word  <= cache_word_nxt;
            cache_tag   <= cache_tag_nxt;
            cache_valid <= cache_valid_nxt;
        end
    end

endmodule
